// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, sequencer state type and the queued command word
package alu_seq_pkg;
    localparam int OPC_W  = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous FIFO with a registered full flag and no write-to-read bypass
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic full_q, full_d;
    logic do_push, do_pop;
    assign empty   = wptr_q == rptr_q;
    assign full    = full_q;
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q[AW-1:0]];
    // next pointers wrap naturally; full is derived from the next occupancy so it is a clean flop
    always_comb begin
        wptr_d = wptr_q + PW'(do_push);
        rptr_d = rptr_q + PW'(do_pop);
        full_d = (wptr_d - rptr_d) == PW'(DEPTH);
    end
    // pointer and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            full_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            full_q <= full_d;
        end
    end
    // storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues one at a time with a watchdog, returns results in order (ALU_SEQ_STATS_EN adds result counters)
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
`ifdef ALU_SEQ_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPC_W-1:0]  cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              alu_req,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic              alu_carry,
    input  logic              alu_of,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OPC_W-1:0]  res_opcode,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_carry,
    output logic              res_of,
`ifdef ALU_SEQ_STATS_EN
    output logic              res_timeout,
    output logic [CNT_W-1:0]  stat_ops,
    output logic [CNT_W-1:0]  stat_timeouts
`else
    output logic              res_timeout
`endif
);
    localparam int TW = $clog2(TIMEOUT);
    cmd_t head, cmd_in, alu_cmd_q, alu_cmd_d;
    logic full, empty, push, pop;
    state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic alu_req_q, alu_req_d;
    logic res_valid_q, res_valid_d;
    logic [OPC_W-1:0] res_opcode_q, res_opcode_d;
    logic [DATA_W-1:0] res_sum_q, res_sum_d;
    logic res_carry_q, res_carry_d, res_of_q, res_of_d, res_timeout_q, res_timeout_d;
    assign cmd_in    = {cmd_opcode, cmd_a, cmd_b};
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && !empty;
    alu_seq_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    // sequencer next state: pop, issue, wait for done or watchdog, hold result until accepted
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        alu_req_d     = 1'b0;
        alu_cmd_d     = alu_cmd_q;
        res_valid_d   = res_valid_q;
        res_opcode_d  = res_opcode_q;
        res_sum_d     = res_sum_q;
        res_carry_d   = res_carry_q;
        res_of_d      = res_of_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: if (!empty) begin
                state_d   = ISSUE;
                alu_req_d = 1'b1;
                alu_cmd_d = head;
                timer_d   = '0;
            end
            ISSUE, WAIT: begin
                timer_d = timer_q + TW'(1);
                if (alu_done || timer_q == TW'(TIMEOUT - 1)) begin
                    state_d       = HOLD;
                    res_valid_d   = 1'b1;
                    res_opcode_d  = alu_cmd_q.opcode;
                    res_sum_d     = alu_done ? alu_sum : '0;
                    res_carry_d   = alu_done && alu_carry;
                    res_of_d      = alu_done && alu_of;
                    res_timeout_d = !alu_done;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: if (res_ready) begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end
    // sequencer and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            alu_req_q     <= 1'b0;
            alu_cmd_q     <= '0;
            res_valid_q   <= 1'b0;
            res_opcode_q  <= '0;
            res_sum_q     <= '0;
            res_carry_q   <= 1'b0;
            res_of_q      <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            alu_req_q     <= alu_req_d;
            alu_cmd_q     <= alu_cmd_d;
            res_valid_q   <= res_valid_d;
            res_opcode_q  <= res_opcode_d;
            res_sum_q     <= res_sum_d;
            res_carry_q   <= res_carry_d;
            res_of_q      <= res_of_d;
            res_timeout_q <= res_timeout_d;
        end
    end
    assign alu_req     = alu_req_q;
    assign alu_opcode  = alu_cmd_q.opcode;
    assign alu_a       = alu_cmd_q.a;
    assign alu_b       = alu_cmd_q.b;
    assign res_valid   = res_valid_q;
    assign res_opcode  = res_opcode_q;
    assign res_sum     = res_sum_q;
    assign res_carry   = res_carry_q;
    assign res_of      = res_of_q;
    assign res_timeout = res_timeout_q;
`ifdef ALU_SEQ_STATS_EN
    logic [CNT_W-1:0] stat_ops_q, stat_ops_d, stat_tmo_q, stat_tmo_d;
    logic acc;
    assign acc = res_valid_q && res_ready;
    // saturating counts of accepted results and of accepted watchdog results
    always_comb begin
        stat_ops_d = (acc && !(&stat_ops_q)) ? stat_ops_q + CNT_W'(1) : stat_ops_q;
        stat_tmo_d = (acc && res_timeout_q && !(&stat_tmo_q)) ? stat_tmo_q + CNT_W'(1) : stat_tmo_q;
    end
    // statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ops_q <= '0;
            stat_tmo_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_tmo_q <= stat_tmo_d;
        end
    end
    assign stat_ops      = stat_ops_q;
    assign stat_timeouts = stat_tmo_q;
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scoreboard bench for alu_cmd_sequencer with a behavioural ALU (ALU_SEQ_STATS_EN also checks counters)
module tb_alu_cmd_sequencer;
    logic clk = 1'b0, reset = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_opcode = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic alu_req;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b;
    logic alu_done = 1'b0, alu_carry = 1'b0, alu_of = 1'b0;
    logic [7:0] alu_sum = '0;
    logic res_valid, res_ready = 1'b0, res_carry, res_of, res_timeout;
    logic [3:0] res_opcode;
    logic [7:0] res_sum;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_timeouts;
`endif
    int tests = 0, fails = 0;
    int alu_delay = 1;
    int model_cnt = -1;
    logic stray = 1'b0, tmo_mode = 1'b0, hs = 1'b0;
    logic [14:0] exp_q[$];

    alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_req(alu_req), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_sum(alu_sum), .alu_carry(alu_carry), .alu_of(alu_of),
        .res_valid(res_valid), .res_ready(res_ready), .res_opcode(res_opcode),
        .res_sum(res_sum), .res_carry(res_carry), .res_of(res_of),
`ifdef ALU_SEQ_STATS_EN
        .res_timeout(res_timeout), .stat_ops(stat_ops), .stat_timeouts(stat_timeouts)
`else
        .res_timeout(res_timeout)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] alu_f(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, b} + {5'b0, op};
        return {r[7:0], r[8], (a[7] == b[7]) && (r[7] != a[7])};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        hs = cmd_valid && cmd_ready;
        if (hs) exp_q.push_back(tmo_mode ? {cmd_opcode, 10'b0, 1'b1}
                                         : {cmd_opcode, alu_f(cmd_opcode, cmd_a, cmd_b), 1'b0});
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_result: observed op %0h sum %0h expected no result", res_opcode, res_sum);
            end else begin
                chk("result", {res_opcode, res_sum, res_carry, res_of, res_timeout}, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
    endtask

    task automatic drain(string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (alu_req) model_cnt = alu_delay;
            else if (model_cnt > 0) model_cnt--;
            else model_cnt = -1;
            alu_done = (model_cnt == 0) || stray;
            {alu_sum, alu_carry, alu_of} = alu_done ? alu_f(alu_opcode, alu_a, alu_b) : 10'h3A5;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        logic [14:0] snap;
        repeat (3) step();
        chk("reset_outs", {cmd_ready, alu_req, alu_opcode, alu_a, alu_b, res_valid,
                           res_opcode, res_sum, res_carry, res_of, res_timeout}, 0);
        reset = 1'b0;
        res_ready = 1'b1;
        step();
        chk("ready_after_reset", cmd_ready, 1);

        alu_delay = 1;
        drive(4'h0, 8'h99, 8'h48);
        step();
        chk("basic_hs", hs, 1);
        cmd_valid = 1'b0;
        chk("basic_req_not_yet", alu_req, 0);
        step();
        chk("basic_req", {alu_req, alu_opcode, alu_a, alu_b}, {1'b1, 4'h0, 8'h99, 8'h48});
        step();
        chk("basic_res_not_yet", res_valid, 0);
        step();
        chk("basic_res", {res_valid, res_opcode, res_sum, res_carry, res_of, res_timeout},
            {1'b1, 4'h0, 8'hE1, 3'b000});
        step();
        chk("basic_drained", {res_valid, 8'(exp_q.size())}, 0);

        alu_delay = 0;
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(4'(i), 8'(i * 16 + 5), 8'(8'h30 + i));
            step();
            acc += int'(hs);
        end
        chk("fill_accepted", acc, 5);
        chk("fill_ready_low", cmd_ready, 0);
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            acc += int'(alu_req) + int'(cmd_ready);
        end
        chk("fill_stalled", acc, 0);
        res_ready = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!hs && n < 10);
        chk("refill_latency", n, 3);
        cmd_valid = 1'b0;
        drain("fill_drained");

        alu_delay = -1;
        res_ready = 1'b0;
        tmo_mode = 1'b1;
        drive(4'h7, 8'h10, 8'h20);
        step();
        cmd_valid = 1'b0;
        tmo_mode = 1'b0;
        n = 0;
        while (!alu_req && n < 10) begin
            step();
            n++;
        end
        chk("tmo_req_seen", alu_req, 1);
        n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        chk("tmo_latency", n, 16);
        chk("tmo_res", {res_opcode, res_sum, res_carry, res_of, res_timeout}, {4'h7, 8'h00, 3'b001});
        stray = 1'b1;
        step();
        stray = 1'b0;
        step();
        step();
        chk("tmo_stray_done", {res_valid, res_opcode, res_sum, res_carry, res_of, res_timeout},
            {1'b1, 4'h7, 8'h00, 3'b001});
        res_ready = 1'b1;
        step();
        chk("tmo_popped", 64'(exp_q.size()), 0);

        alu_delay = 1;
        res_ready = 1'b0;
        drive(4'h3, 8'h7F, 8'h01);
        step();
        drive(4'h4, 8'hFF, 8'h01);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        snap = {res_opcode, res_sum, res_carry, res_of, res_timeout};
        chk("bp_first", {res_valid, snap}, {1'b1, 4'h3, 8'h83, 3'b010});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {res_valid, alu_req, res_opcode, res_sum, res_carry, res_of, res_timeout},
                {2'b10, snap});
        end
        res_ready = 1'b1;
        step();
        chk("bp_req_gap", alu_req, 0);
        step();
        chk("bp_next_req", {alu_req, alu_opcode, alu_a}, {1'b1, 4'h4, 8'hFF});
        drain("bp_drained");
`ifdef ALU_SEQ_STATS_EN
        chk("stat_counts", {stat_ops, stat_timeouts}, {16'd10, 16'd1});
`endif

        alu_delay = -1;
        drive(4'h1, 8'h01, 8'h02);
        step();
        drive(4'h2, 8'h03, 8'h04);
        step();
        drive(4'h3, 8'h05, 8'h06);
        step();
        cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("midrst_outs", {cmd_ready, alu_req, alu_opcode, alu_a, alu_b, res_valid,
                            res_opcode, res_sum, res_carry, res_of, res_timeout}, 0);
`ifdef ALU_SEQ_STATS_EN
        chk("midrst_stats", {stat_ops, stat_timeouts}, 0);
`endif
        exp_q.delete();
        reset = 1'b0;
        step();
        chk("midrst_ready", cmd_ready, 1);
        acc = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            acc += int'(alu_req) + int'(res_valid);
        end
        chk("midrst_quiet", acc, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
